adder_bist_ctrl: RTL and testbench

- Built-in self-test controller that drives the operand side of the registered full_adder (A, B, C_in) and checks its result side (sum, C_out).
- On start, it applies four fixed corner vectors and then LFSR-generated vectors.
- It predicts each result internally, aligns the prediction to the adder latency, compares, and reports pass/fail, error count and first failing vector index.
- Sits beside full_adder in the top level; the bench drives only start.

---
 rtl/adder_bist_pkg.sv | 33 +++
 rtl/adder_bist_ctrl_lfsr.sv | 39 +++
 rtl/adder_bist_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_adder_bist_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Shared constants for the full_adder BIST controller: FSM encoding, LFSR taps,
// corner-vector patterns and the error-counter width.
package adder_bist_pkg;

  typedef logic [1:0] bist_state_t;

  localparam bist_state_t StIdle  = 2'd0;
  localparam bist_state_t StDrive = 2'd1;
  localparam bist_state_t StDrain = 2'd2;
  localparam bist_state_t StDone  = 2'd3;

  // Fibonacci taps, 1-based bit positions of the (2*WIDTH+1)-bit LFSR.
  localparam int unsigned LfsrTapA4 = 9;
  localparam int unsigned LfsrTapB4 = 5;
  localparam int unsigned LfsrTapA8 = 17;
  localparam int unsigned LfsrTapB8 = 14;

  localparam int unsigned NumCorner = 4;
  // Alternating patterns; the low WIDTH bits give 1010.. / 0101.. for WIDTH 4 or 8.
  localparam logic [7:0] CornerAltA = 8'hAA;
  localparam logic [7:0] CornerAltB = 8'h55;

  localparam int unsigned ErrW = 8;

  function automatic int unsigned lfsr_tap_a(input int unsigned width);
    return (width == 8) ? LfsrTapA8 : LfsrTapA4;
  endfunction

  function automatic int unsigned lfsr_tap_b(input int unsigned width);
    return (width == 8) ? LfsrTapB8 : LfsrTapB4;
  endfunction

endpackage

// File: rtl/adder_bist_ctrl_lfsr.sv
// Fibonacci LFSR with synchronous reset/load to the seed and a step enable.
// An all-zero seed would lock up, so it is replaced by 1.
module bist_lfsr #(
  parameter int unsigned     Width = 9,
  parameter int unsigned     TapA  = 9,
  parameter int unsigned     TapB  = 5,
  parameter logic [Width-1:0] Seed = Width'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [Width-1:0] state_o
);

  localparam logic [Width-1:0] SeedEff = (Seed == '0) ? Width'(1) : Seed;

  logic [Width-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SeedEff;
    end else if (en_i) begin
      state_d = {state_q[Width-2:0], state_q[TapA-1] ^ state_q[TapB-1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SeedEff;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for the registered full_adder: drives corner then LFSR vectors,
// predicts each result, aligns it to the adder latency and tallies mismatches.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       ADDER_LAT   = 1,
  parameter int unsigned       NUM_VECTORS = 32,
  parameter logic [2*WIDTH:0]  LFSR_SEED   = 'h1A5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             C_in,
  input  logic [WIDTH-1:0] sum,
  input  logic             C_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ErrW-1:0]  err_count,
  output logic [ErrW-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned LfsrW     = 2 * WIDTH + 1;
  localparam logic [7:0]  LastIdx   = 8'(NUM_VECTORS - 1);
  localparam logic [7:0]  DrainLast = 8'(ADDER_LAT - 1);

  bist_state_t state_q, state_d;
  logic [7:0] vec_idx_q, vec_idx_d;
  logic [7:0] drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic cin_q, cin_d;
  logic vld_q, vld_d;
  logic [7:0] idx_q, idx_d;

  logic [WIDTH:0] pipe_exp_q [ADDER_LAT];
  logic [WIDTH:0] pipe_exp_d [ADDER_LAT];
  logic           pipe_vld_q [ADDER_LAT];
  logic           pipe_vld_d [ADDER_LAT];
  logic [7:0]     pipe_idx_q [ADDER_LAT];
  logic [7:0]     pipe_idx_d [ADDER_LAT];

  logic [ErrW-1:0] err_q, err_d, ffi_q, ffi_d;
  logic ffv_q, ffv_d, done_q, done_d, pass_q, pass_d;

  logic launch, lfsr_en, mismatch;
  logic [WIDTH:0] exp_in;
  logic [LfsrW-1:0] lfsr_state;

  assign launch  = start && ((state_q == StIdle) || (state_q == StDone));
  assign lfsr_en = (state_q == StDrive) && (vec_idx_q >= 8'(NumCorner));

  bist_lfsr #(
    .Width (LfsrW),
    .TapA  (lfsr_tap_a(WIDTH)),
    .TapB  (lfsr_tap_b(WIDTH)),
    .Seed  (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .load_i  (launch),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    drain_cnt_d = drain_cnt_q;
    a_d         = '0;
    b_d         = '0;
    cin_d       = 1'b0;
    vld_d       = 1'b0;
    idx_d       = '0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StDrive;
          vec_idx_d = '0;
        end
      end
      StDrive: begin
        vld_d = 1'b1;
        idx_d = vec_idx_q;
        case (vec_idx_q)
          8'd0: begin a_d = '0; b_d = '0; cin_d = 1'b0; end
          8'd1: begin a_d = '1; b_d = '1; cin_d = 1'b1; end
          8'd2: begin a_d = '1; b_d = '0; cin_d = 1'b1; end
          8'd3: begin
            a_d   = CornerAltA[WIDTH-1:0];
            b_d   = CornerAltB[WIDTH-1:0];
            cin_d = 1'b0;
          end
          default: begin
            a_d   = lfsr_state[WIDTH-1:0];
            b_d   = lfsr_state[2*WIDTH-1:WIDTH];
            cin_d = lfsr_state[2*WIDTH];
          end
        endcase
        vec_idx_d = vec_idx_q + 8'd1;
        if (vec_idx_q == LastIdx) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Prediction is taken from the registered operands so it lines up with the adder input.
  assign exp_in = {1'b0, a_q} + {1'b0, b_q} + (WIDTH + 1)'(cin_q);

  always_comb begin
    pipe_exp_d[0] = exp_in;
    pipe_vld_d[0] = vld_q;
    pipe_idx_d[0] = idx_q;
    for (int i = 1; i < ADDER_LAT; i++) begin
      pipe_exp_d[i] = pipe_exp_q[i-1];
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
  end

  assign mismatch = pipe_vld_q[ADDER_LAT-1] && ({C_out, sum} != pipe_exp_q[ADDER_LAT-1]);

  always_comb begin
    err_d = err_q;
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    if (launch) begin
      err_d = '0;
      ffv_d = 1'b0;
      ffi_d = '0;
    end else if (mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
      if (!ffv_q) begin
        ffv_d = 1'b1;
        ffi_d = pipe_idx_q[ADDER_LAT-1];
      end
    end
    done_d = (state_q == StDone) && !launch;
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      vec_idx_q   <= '0;
      drain_cnt_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      vld_q       <= 1'b0;
      idx_q       <= '0;
      err_q       <= '0;
      ffv_q       <= 1'b0;
      ffi_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      for (int i = 0; i < ADDER_LAT; i++) begin
        pipe_exp_q[i] <= '0;
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      drain_cnt_q <= drain_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      vld_q       <= vld_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      ffv_q       <= ffv_d;
      ffi_q       <= ffi_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      for (int i = 0; i < ADDER_LAT; i++) begin
        pipe_exp_q[i] <= pipe_exp_d[i];
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_idx_q[i] <= pipe_idx_d[i];
      end
    end
  end

  assign A                = a_q;
  assign B                = b_q;
  assign C_in             = cin_q;
  assign busy             = (state_q == StDrive) || (state_q == StDrain);
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: two controllers (8 vectors / latency 1 and 255 vectors /
// latency 3) each beside a behavioural adder with selectable faults.
module tb_adder_bist_ctrl;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;

  logic [3:0] a_A, a_B, b_A, b_B, sum_a, sum_b;
  logic a_C, b_C, cout_a, cout_b;
  logic busy_a, done_a, pass_a, ffv_a, busy_b, done_b, pass_b, ffv_b;
  logic [7:0] err_a, ffi_a, err_b, ffi_b;

  int mode_a = 0, mode_b = 0, fsel = 0;
  int errors = 0, checks = 0;
  bit sel = 1'b0;

  always #5 Clock = ~Clock;

  adder_bist_ctrl #(
    .WIDTH(4), .ADDER_LAT(1), .NUM_VECTORS(8), .LFSR_SEED(9'h1A5)
  ) dut_a (
    .Clock(Clock), .Reset(Reset), .start(start_a), .A(a_A), .B(a_B), .C_in(a_C),
    .sum(sum_a), .C_out(cout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail_vec(ffi_a), .first_fail_valid(ffv_a)
  );

  adder_bist_ctrl #(
    .WIDTH(4), .ADDER_LAT(3), .NUM_VECTORS(255), .LFSR_SEED(9'h000)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .start(start_b), .A(b_A), .B(b_B), .C_in(b_C),
    .sum(sum_b), .C_out(cout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail_vec(ffi_b), .first_fail_valid(ffv_b)
  );

  // Behavioural adder result with an optional planted fault.
  function automatic int adder_out(input int a, input int b, input int c, input int mode,
                                   input int s);
    int r;
    r = a + b + c;
    case (mode)
      1: r = r & ~1;
      2: r = r ^ 16;
      3: if ((a % 4) == s) r = r ^ 2;
      default: ;
    endcase
    return r;
  endfunction

  logic [4:0] res_a;
  logic [4:0] res_b [3];

  always_ff @(posedge Clock) begin
    res_a    <= 5'(adder_out(int'(a_A), int'(a_B), int'(a_C), mode_a, fsel));
    res_b[0] <= 5'(adder_out(int'(b_A), int'(b_B), int'(b_C), mode_b, fsel));
    res_b[1] <= res_b[0];
    res_b[2] <= res_b[1];
  end

  assign {cout_a, sum_a} = res_a;
  assign {cout_b, sum_b} = res_b[2];

  logic [3:0] o_A, o_B;
  logic o_C, o_busy, o_done, o_pass, o_ffv;
  logic [7:0] o_err, o_ffi;

  always_comb begin
    o_A = sel ? b_A : a_A;
    o_B = sel ? b_B : a_B;
    o_C = sel ? b_C : a_C;
    o_busy = sel ? busy_b : busy_a;
    o_done = sel ? done_b : done_a;
    o_pass = sel ? pass_b : pass_a;
    o_ffv = sel ? ffv_b : ffv_a;
    o_err = sel ? err_b : err_a;
    o_ffi = sel ? ffi_b : ffi_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A"}, 32'(o_A), 0);
    check({tag, "_B"}, 32'(o_B), 0);
    check({tag, "_C"}, 32'(o_C), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_pass"}, 32'(o_pass), 0);
    check({tag, "_err"}, 32'(o_err), 0);
    check({tag, "_ffv"}, 32'(o_ffv), 0);
    check({tag, "_ffi"}, 32'(o_ffi), 0);
  endtask

  // Reference vector list built straight from the sequence rules.
  int ref_a [256];
  int ref_b [256];
  int ref_c [256];

  task automatic build_ref(input int n, input int seed);
    int s;
    s = (seed == 0) ? 1 : seed;
    for (int i = 0; i < n; i++) begin
      case (i)
        0: begin ref_a[i] = 0;  ref_b[i] = 0;  ref_c[i] = 0; end
        1: begin ref_a[i] = 15; ref_b[i] = 15; ref_c[i] = 1; end
        2: begin ref_a[i] = 15; ref_b[i] = 0;  ref_c[i] = 1; end
        3: begin ref_a[i] = 10; ref_b[i] = 5;  ref_c[i] = 0; end
        default: begin
          ref_a[i] = s % 16;
          ref_b[i] = (s / 16) % 16;
          ref_c[i] = (s / 256) % 2;
          s = ((s * 2) + (((s / 256) + (s / 16)) % 2)) % 512;
        end
      endcase
    end
  endtask

  task automatic run(input bit which, input int mode, input bit glitch);
    int n, lat, cyc, busy_cnt, exp_err, exp_ff;
    bit ff_set;
    n   = which ? 255 : 8;
    lat = which ? 3 : 1;
    build_ref(n, which ? 0 : 'h1A5);
    exp_err = 0;
    exp_ff  = 0;
    ff_set  = 1'b0;
    for (int i = 0; i < n; i++) begin
      int good;
      good = ref_a[i] + ref_b[i] + ref_c[i];
      if (adder_out(ref_a[i], ref_b[i], ref_c[i], mode, fsel) != good) begin
        if (exp_err < 255) exp_err++;
        if (!ff_set) begin
          ff_set = 1'b1;
          exp_ff = i;
        end
      end
    end
    if (which) mode_b = mode;
    else mode_a = mode;
    sel = which;
    repeat ($urandom_range(1, 4)) @(posedge Clock);
    #1 set_start(1'b1);
    @(posedge Clock);
    #1 set_start(1'b0);
    check("busy_rise", 32'(o_busy), 1);
    check("done_fall", 32'(o_done), 0);
    busy_cnt = int'(o_busy);
    for (int k = 0; k < n; k++) begin
      if (glitch && $urandom_range(0, 3) == 0) set_start(1'b1);
      @(posedge Clock);
      #1 set_start(1'b0);
      busy_cnt += int'(o_busy);
      check($sformatf("vec%0d", k), {o_C, o_B, o_A},
            32'((ref_c[k] * 256) + (ref_b[k] * 16) + ref_a[k]));
    end
    cyc = n;
    while (!o_done && cyc < n + lat + 8) begin
      if (glitch && cyc <= n + lat - 1) set_start(1'b1);
      @(posedge Clock);
      #1 set_start(1'b0);
      cyc++;
      busy_cnt += int'(o_busy);
    end
    check("done_cycle", 32'(cyc), 32'(n + lat + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(n + lat));
    check("busy_in_done", 32'(o_busy), 0);
    check("pass", 32'(o_pass), 32'(exp_err == 0));
    check("err_count", 32'(o_err), 32'(exp_err));
    check("ff_valid", 32'(o_ffv), 32'(ff_set));
    if (ff_set) check("ff_vec", 32'(o_ffi), 32'(exp_ff));
    check("ops_idle", {o_C, o_B, o_A}, 0);
    @(posedge Clock);
    #1;
    check("done_hold", 32'(o_done), 1);
    check("err_hold", 32'(o_err), 32'(exp_err));
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    sel = 1'b0;
    check_all_zero("rst_a");
    sel = 1'b1;
    check_all_zero("rst_b");
    Reset = 1'b0;
    fsel = int'($urandom_range(0, 3));

    run(1'b0, 0, 1'b0);
    run(1'b0, 0, 1'b1);
    run(1'b0, 1, 1'b1);
    run(1'b0, 2, 1'b0);
    run(1'b0, 3, 1'b1);
    run(1'b1, 2, 1'b0);
    run(1'b1, 1, 1'b1);

    // Abort a run partway through DRIVE, then confirm a clean rerun.
    sel = 1'b0;
    mode_a = 0;
    @(posedge Clock);
    #1 start_a = 1'b1;
    @(posedge Clock);
    #1 start_a = 1'b0;
    repeat (5) @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1;
    check_all_zero("midrst_a");
    Reset = 1'b0;
    run(1'b0, 0, 1'b0);

    repeat (3) begin
      fsel = int'($urandom_range(0, 3));
      run(1'(($urandom_range(0, 3) == 0)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
